// File: rtl/vend_pkg.sv
// Shared coin codes, state encoding and coin valuation for the vending credit controller.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_5    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_e;

    // Credit units carried by a coin code; COIN_NONE is worth nothing.
    function automatic logic [2:0] coin_value(input logic [1:0] code);
        logic [2:0] v;
        case (code)
            COIN_1:  v = 3'd1;
            COIN_2:  v = 3'd2;
            COIN_5:  v = 3'd5;
            default: v = 3'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_change_unit.sv
// Change payout loop: greedy coin choice from the registered credit, valid/ack
// handshake toward the hopper, and the credit remaining after an accepted coin.
module vend_change_unit
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 4
) (
    input  logic                active,
    input  logic [CREDIT_W-1:0] credit,
    input  logic                ack,
    output logic [1:0]          coin_code,
    output logic                coin_valid,
    output logic [CREDIT_W-1:0] credit_next,
    output logic                done
);

    logic [CREDIT_W-1:0] coin_val;

    // Greedy coin selection and handshake; purely a decode of registered state and credit plus ack.
    always_comb begin
        coin_code   = COIN_NONE;
        coin_valid  = 1'b0;
        coin_val    = '0;
        credit_next = credit;
        done        = 1'b0;
        if (active) begin
            coin_valid = 1'b1;
            if (credit >= CREDIT_W'(5)) begin
                coin_code = COIN_5;
            end else if (credit >= CREDIT_W'(2)) begin
                coin_code = COIN_2;
            end else begin
                coin_code = COIN_1;
            end
            coin_val = CREDIT_W'(coin_value(coin_code));
            if (ack) begin
                // Saturate at zero so a stray zero-credit entry can never wrap.
                if (coin_val >= credit) begin
                    credit_next = '0;
                    done        = 1'b1;
                end else begin
                    credit_next = credit - coin_val;
                end
            end
        end
    end

endmodule

// File: rtl/vend_credit_controller.sv
// Credit-and-change sequencer: accumulates coins, dispenses a soda on select,
// then pays back the remainder one coin per hopper handshake.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | accepting coins; cancel refunds, sel vends when credit >= PRICE
//   ST_VEND   | soda pulse cycle; credit already holds the change due
//   ST_CHANGE | offering change coins to the hopper until credit reaches 0
module vend_credit_controller
    import vend_pkg::*;
#(
    parameter int PRICE      = 6,
    parameter int MAX_CREDIT = 12,
    parameter int CREDIT_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin_in,
    input  logic                sel,
    input  logic                cancel,
    input  logic                coin_out_ack,
    output logic                soda,
    output logic [1:0]          coin_out,
    output logic                coin_out_valid,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int SUM_W = CREDIT_W + 1;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                soda_q, soda_d;
    logic                coin_reject_q, coin_reject_d;

    logic [SUM_W-1:0]    coin_v;
    logic [SUM_W-1:0]    coin_sum;
    logic [SUM_W-1:0]    accepted_v;
    logic [SUM_W-1:0]    total;
    logic                coin_fits;
    logic                in_idle;

    logic [1:0]          chg_coin;
    logic                chg_valid;
    logic [CREDIT_W-1:0] chg_credit_next;
    logic                chg_done;

    vend_change_unit #(
        .CREDIT_W (CREDIT_W)
    ) u_change (
        .active      (state_q == ST_CHANGE),
        .credit      (credit_q),
        .ack         (coin_out_ack),
        .coin_code   (chg_coin),
        .coin_valid  (chg_valid),
        .credit_next (chg_credit_next),
        .done        (chg_done)
    );

    // Next-state logic: coin is credited first, then cancel, then sel, all in one cycle.
    always_comb begin
        in_idle       = (state_q == ST_IDLE);
        coin_v        = SUM_W'(coin_value(coin_in));
        coin_sum      = {1'b0, credit_q} + coin_v;
        coin_fits     = (coin_sum <= SUM_W'(MAX_CREDIT));
        accepted_v    = (in_idle && coin_fits) ? coin_v : '0;
        total         = {1'b0, credit_q} + accepted_v;
        coin_reject_d = (coin_in != COIN_NONE) && !(in_idle && coin_fits);
        state_d       = state_q;
        credit_d      = credit_q;
        case (state_q)
            ST_IDLE: begin
                credit_d = CREDIT_W'(total);
                if (cancel) begin
                    if (total != '0) state_d = ST_CHANGE;
                end else if (sel && (credit_q >= CREDIT_W'(PRICE))) begin
                    credit_d = CREDIT_W'(total - SUM_W'(PRICE));
                    state_d  = ST_VEND;
                end
            end
            ST_VEND: begin
                state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                credit_d = chg_credit_next;
                if (chg_done) state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
            end
        endcase
        soda_d = (state_d == ST_VEND);
    end

    // State, credit and pulse outputs; reset wins over every input in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            soda_q        <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            soda_q        <= soda_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    assign soda           = soda_q;
    assign coin_reject    = coin_reject_q;
    assign credit         = credit_q;
    assign busy           = (state_q != ST_IDLE);
    assign coin_out       = chg_coin;
    assign coin_out_valid = chg_valid;

endmodule

// File: tb/tb_vend_credit_controller.sv
// Directed, table-driven bench for vend_credit_controller (PRICE=6, MAX_CREDIT=12).
module tb_vend_credit_controller;

    logic       clk;
    logic       reset;
    logic [1:0] coin_in;
    logic       sel;
    logic       cancel;
    logic       coin_out_ack;
    logic       soda;
    logic [1:0] coin_out;
    logic       coin_out_valid;
    logic       coin_reject;
    logic [3:0] credit;
    logic       busy;

    int errors = 0;
    int checks = 0;

    vend_credit_controller #(
        .PRICE      (6),
        .MAX_CREDIT (12),
        .CREDIT_W   (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .coin_in        (coin_in),
        .sel            (sel),
        .cancel         (cancel),
        .coin_out_ack   (coin_out_ack),
        .soda           (soda),
        .coin_out       (coin_out),
        .coin_out_valid (coin_out_valid),
        .coin_reject    (coin_reject),
        .credit         (credit),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [1:0] coin;
        logic       sel;
        logic       can;
        logic       ack;
        logic       e_soda;
        logic [1:0] e_cout;
        logic       e_valid;
        logic       e_rej;
        logic [3:0] e_credit;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string n, logic r, logic [1:0] c, logic s, logic k, logic a,
                                logic es, logic [1:0] eco, logic ev, logic er,
                                logic [3:0] ecr, logic eb);
        vec_t v;
        v.name = n; v.rst = r; v.coin = c; v.sel = s; v.can = k; v.ack = a;
        v.e_soda = es; v.e_cout = eco; v.e_valid = ev; v.e_rej = er;
        v.e_credit = ecr; v.e_busy = eb;
        vecs.push_back(v);
    endfunction

    task automatic chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic drive(logic r, logic [1:0] c, logic s, logic k, logic a);
        reset = r; coin_in = c; sel = s; cancel = k; coin_out_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(string n, logic es, logic [1:0] eco, logic ev, logic er,
                             logic [3:0] ecr, logic eb);
        chk({n, ".soda"},   int'(soda),           int'(es));
        chk({n, ".cout"},   int'(coin_out),       int'(eco));
        chk({n, ".valid"},  int'(coin_out_valid), int'(ev));
        chk({n, ".reject"}, int'(coin_reject),    int'(er));
        chk({n, ".credit"}, int'(credit),         int'(ecr));
        chk({n, ".busy"},   int'(busy),           int'(eb));
    endtask

    initial begin
        logic [1:0] held_cout;
        //   name          rst coin  sel can ack | soda cout  vld rej cr  busy
        add("reset",       1, 2'b00, 0, 0, 0,     0, 2'b00, 0, 0, 0,  0);
        // coin 5 + coin 2, sel -> soda, one 1-unit coin of change
        add("t1_c5",       0, 2'b11, 0, 0, 0,     0, 2'b00, 0, 0, 5,  0);
        add("t1_c2",       0, 2'b10, 0, 0, 0,     0, 2'b00, 0, 0, 7,  0);
        add("t1_sel",      0, 2'b00, 1, 0, 0,     1, 2'b00, 0, 0, 1,  1);
        add("t1_chg",      0, 2'b00, 0, 0, 0,     0, 2'b01, 1, 0, 1,  1);
        add("t1_ack",      0, 2'b00, 0, 0, 1,     0, 2'b00, 0, 0, 0,  0);
        // insufficient credit: sel ignored
        add("t3_c2a",      0, 2'b10, 0, 0, 0,     0, 2'b00, 0, 0, 2,  0);
        add("t3_c2b",      0, 2'b10, 0, 0, 0,     0, 2'b00, 0, 0, 4,  0);
        add("t3_sel",      0, 2'b00, 1, 0, 0,     0, 2'b00, 0, 0, 4,  0);
        // overflow reject, then cancel pays 5,5
        add("t2_c5",       0, 2'b11, 0, 0, 0,     0, 2'b00, 0, 0, 9,  0);
        add("t2_c1",       0, 2'b01, 0, 0, 0,     0, 2'b00, 0, 0, 10, 0);
        add("t2_rej",      0, 2'b11, 0, 0, 0,     0, 2'b00, 0, 1, 10, 0);
        add("t2_can",      0, 2'b00, 0, 1, 0,     0, 2'b11, 1, 0, 10, 1);
        add("t2_ack1",     0, 2'b00, 0, 0, 1,     0, 2'b11, 1, 0, 5,  1);
        add("t2_ack2",     0, 2'b00, 0, 0, 1,     0, 2'b00, 0, 0, 0,  0);
        // fill to exactly MAX_CREDIT, vend with ack tied high
        add("t5_c5a",      0, 2'b11, 0, 0, 1,     0, 2'b00, 0, 0, 5,  0);
        add("t5_c5b",      0, 2'b11, 0, 0, 1,     0, 2'b00, 0, 0, 10, 0);
        add("t5_c2",       0, 2'b10, 0, 0, 1,     0, 2'b00, 0, 0, 12, 0);
        add("t5_sel",      0, 2'b00, 1, 0, 1,     1, 2'b00, 0, 0, 6,  1);
        add("t5_p5",       0, 2'b00, 0, 0, 1,     0, 2'b11, 1, 0, 6,  1);
        add("t5_p1",       0, 2'b00, 0, 0, 1,     0, 2'b01, 1, 0, 1,  1);
        add("t5_idle",     0, 2'b00, 0, 0, 1,     0, 2'b00, 0, 0, 0,  0);
        // cancel with zero credit stays idle
        add("can_zero",    0, 2'b00, 0, 1, 0,     0, 2'b00, 0, 0, 0,  0);
        // coin + sel + cancel together: coin credited, cancel wins
        add("all3",        0, 2'b01, 1, 1, 0,     0, 2'b01, 1, 0, 1,  1);
        add("all3_ack",    0, 2'b00, 0, 0, 1,     0, 2'b00, 0, 0, 0,  0);
        // coin + sel at credit 6: credit 6+2-6 = 2 change
        add("cs_c5",       0, 2'b11, 0, 0, 0,     0, 2'b00, 0, 0, 5,  0);
        add("cs_c1",       0, 2'b01, 0, 0, 0,     0, 2'b00, 0, 0, 6,  0);
        add("cs_sel",      0, 2'b10, 1, 0, 0,     1, 2'b00, 0, 0, 2,  1);
        add("cs_chg",      0, 2'b00, 0, 0, 0,     0, 2'b10, 1, 0, 2,  1);
        add("cs_ack",      0, 2'b00, 0, 0, 1,     0, 2'b00, 0, 0, 0,  0);
        // sel uses registered credit: 5 + coin 1 with sel does not vend yet
        add("rg_c5",       0, 2'b11, 0, 0, 0,     0, 2'b00, 0, 0, 5,  0);
        add("rg_c1sel",    0, 2'b01, 1, 0, 0,     0, 2'b00, 0, 0, 6,  0);
        add("rg_sel",      0, 2'b00, 1, 0, 0,     1, 2'b00, 0, 0, 0,  1);
        add("rg_noch",     0, 2'b00, 0, 0, 0,     0, 2'b00, 0, 0, 0,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].coin, vecs[i].sel, vecs[i].can, vecs[i].ack);
            check_all(vecs[i].name, vecs[i].e_soda, vecs[i].e_cout, vecs[i].e_valid,
                      vecs[i].e_rej, vecs[i].e_credit, vecs[i].e_busy);
        end

        // Stall: ack low for 5 cycles, coin inserted meanwhile is rejected.
        drive(0, 2'b10, 0, 0, 0);
        drive(0, 2'b00, 0, 1, 0);
        check_all("st_enter", 0, 2'b10, 1, 0, 2, 1);
        held_cout = coin_out;
        for (int i = 0; i < 5; i++) begin
            drive(0, (i == 2) ? 2'b01 : 2'b00, 0, 0, 0);
            check_all($sformatf("st_hold%0d", i), 0, 2'b10, 1, (i == 2) ? 1'b1 : 1'b0, 2, 1);
            chk($sformatf("st_stable%0d", i), int'(coin_out), int'(held_cout));
        end
        drive(0, 2'b00, 0, 0, 1);
        check_all("st_ack", 0, 2'b00, 0, 0, 0, 0);

        // Reset during CHANGE discards credit; next coin accepted normally.
        drive(0, 2'b11, 0, 0, 0);
        drive(0, 2'b11, 0, 0, 0);
        drive(0, 2'b00, 0, 1, 0);
        check_all("rs_chg", 0, 2'b11, 1, 0, 10, 1);
        drive(1, 2'b01, 1, 1, 1);
        check_all("rs_rst", 0, 2'b00, 0, 0, 0, 0);
        drive(0, 2'b10, 0, 0, 0);
        check_all("rs_coin", 0, 2'b00, 0, 0, 2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
